// File: rtl/text_pkg.sv
// Shared geometry, control codes and FSM state type for the tile-buffer writer.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 7;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  localparam logic [6:0] CR = 7'h0D;
  localparam logic [6:0] LF = 7'h0A;
  localparam logic [6:0] BS = 7'h08;
  localparam logic [6:0] FF = 7'h0C;

  typedef enum logic {CLEAR, IDLE} state_t;

  // Backspace target: step left, wrap to the end of the previous row, stick at (0,0).
  function automatic void retreat(input int unsigned col, input int unsigned row,
                                  input int unsigned cols,
                                  output int unsigned ncol, output int unsigned nrow);
    ncol = col;
    nrow = row;
    if (col > 0) begin
      ncol = col - 1;
    end else if (row > 0) begin
      ncol = cols - 1;
      nrow = row - 1;
    end
  endfunction

endpackage

// File: rtl/tile_cursor.sv
// Column/row register pair over the tile grid with row-major wrap, backspace,
// newline, carriage-return and home controls.
module tile_cursor #(
  parameter int COLS  = text_pkg::COLS,
  parameter int ROWS  = text_pkg::ROWS,
  parameter int COL_W = text_pkg::COL_W,
  parameter int ROW_W = text_pkg::ROW_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_zero,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_nl,
  input  logic             i_cr,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_at_last
);
  import text_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  int unsigned      w_prev_col;
  int unsigned      w_prev_row;
  logic [ROW_W-1:0] w_row_wrap;

  always_comb begin
    w_prev_col = '0;
    w_prev_row = '0;
    retreat(32'(r_col), 32'(r_row), COLS, w_prev_col, w_prev_row);
    w_row_wrap = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_zero) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= w_row_wrap;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (i_dec) begin
      r_col <= COL_W'(w_prev_col);
      r_row <= ROW_W'(w_prev_row);
    end else if (i_nl) begin
      r_col <= '0;
      r_row <= w_row_wrap;
    end else if (i_cr) begin
      r_col <= '0;
    end
  end

  assign o_col     = r_col;
  assign o_row     = r_row;
  assign o_at_last = (r_col == LAST_COL) && (r_row == LAST_ROW);

endmodule

// File: rtl/text_buffer_writer.sv
// Write-side producer for the tile buffer: clear sweep after reset/request,
// then character stream with cursor tracking and CR/LF/BS/FF handling.
module text_buffer_writer #(
  parameter int                COLS       = text_pkg::COLS,
  parameter int                ROWS       = text_pkg::ROWS,
  parameter int                CHAR_W     = text_pkg::CHAR_W,
  parameter int                COL_W      = text_pkg::COL_W,
  parameter int                ROW_W      = text_pkg::ROW_W,
  parameter logic [CHAR_W-1:0] CLEAR_CHAR = '0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              char_valid_i,
  input  logic [CHAR_W-1:0] char_i,
  output logic              char_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              wr_en_o,
  output logic [COL_W-1:0]  col_w_o,
  output logic [ROW_W-1:0]  row_w_o,
  output logic [CHAR_W-1:0] din_o,
  output logic [COL_W-1:0]  cursor_col_o,
  output logic [ROW_W-1:0]  cursor_row_o
);
  import text_pkg::*;

  state_t            r_state, w_state_nx;
  logic              r_sweep_done, w_sweep_done_nx;
  logic              r_wr_en, w_wr_en_nx;
  logic [COL_W-1:0]  r_col_w, w_col_w_nx;
  logic [ROW_W-1:0]  r_row_w, w_row_w_nx;
  logic [CHAR_W-1:0] r_din, w_din_nx;

  logic              w_accept;
  logic              w_swp_zero, w_swp_inc, w_swp_last;
  logic [COL_W-1:0]  w_swp_col;
  logic [ROW_W-1:0]  w_swp_row;
  logic              w_cur_zero, w_cur_inc, w_cur_dec, w_cur_nl, w_cur_cr, w_cur_last;
  logic [COL_W-1:0]  w_cur_col;
  logic [ROW_W-1:0]  w_cur_row;
  int unsigned       w_bs_col, w_bs_row;

  tile_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_sweep (
    .i_clk(clk_i), .i_rst_n(rstn_i),
    .i_zero(w_swp_zero), .i_inc(w_swp_inc), .i_dec(1'b0), .i_nl(1'b0), .i_cr(1'b0),
    .o_col(w_swp_col), .o_row(w_swp_row), .o_at_last(w_swp_last)
  );

  tile_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_cursor (
    .i_clk(clk_i), .i_rst_n(rstn_i),
    .i_zero(w_cur_zero), .i_inc(w_cur_inc), .i_dec(w_cur_dec), .i_nl(w_cur_nl), .i_cr(w_cur_cr),
    .o_col(w_cur_col), .o_row(w_cur_row), .o_at_last(w_cur_last)
  );

  assign char_ready_o = (r_state == IDLE) && !clear_i;
  assign w_accept     = char_valid_i && char_ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= CLEAR;
    else         r_state <= w_state_nx;
  end

  // The sweep stays in CLEAR one extra edge after the last tile so that
  // wr_en drops together with the transition to IDLE.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      CLEAR:   if (r_sweep_done) w_state_nx = IDLE;
      IDLE:    if (clear_i || (w_accept && char_i == FF)) w_state_nx = CLEAR;
      default: w_state_nx = CLEAR;
    endcase
  end

  always_comb begin
    w_wr_en_nx      = 1'b0;
    w_col_w_nx      = r_col_w;
    w_row_w_nx      = r_row_w;
    w_din_nx        = r_din;
    w_sweep_done_nx = r_sweep_done;
    w_swp_zero      = 1'b0;
    w_swp_inc       = 1'b0;
    w_cur_zero      = 1'b0;
    w_cur_inc       = 1'b0;
    w_cur_dec       = 1'b0;
    w_cur_nl        = 1'b0;
    w_cur_cr        = 1'b0;
    w_bs_col        = '0;
    w_bs_row        = '0;
    retreat(32'(w_cur_col), 32'(w_cur_row), COLS, w_bs_col, w_bs_row);
    case (r_state)
      CLEAR: begin
        w_cur_zero = 1'b1;
        if (!r_sweep_done) begin
          w_wr_en_nx      = 1'b1;
          w_col_w_nx      = w_swp_col;
          w_row_w_nx      = w_swp_row;
          w_din_nx        = CLEAR_CHAR;
          w_swp_inc       = 1'b1;
          w_sweep_done_nx = w_swp_last;
        end
      end
      IDLE: begin
        if (clear_i) begin
          w_swp_zero      = 1'b1;
          w_cur_zero      = 1'b1;
          w_sweep_done_nx = 1'b0;
        end else if (w_accept) begin
          case (char_i)
            CR: w_cur_cr = 1'b1;
            LF: w_cur_nl = 1'b1;
            BS: begin
              w_cur_dec  = 1'b1;
              w_wr_en_nx = 1'b1;
              w_col_w_nx = COL_W'(w_bs_col);
              w_row_w_nx = ROW_W'(w_bs_row);
              w_din_nx   = CLEAR_CHAR;
            end
            FF: begin
              w_swp_zero      = 1'b1;
              w_cur_zero      = 1'b1;
              w_sweep_done_nx = 1'b0;
            end
            default: begin
              w_wr_en_nx = 1'b1;
              w_col_w_nx = w_cur_col;
              w_row_w_nx = w_cur_row;
              w_din_nx   = char_i;
              w_cur_zero = w_cur_last;
              w_cur_inc  = !w_cur_last;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_en      <= 1'b0;
      r_col_w      <= '0;
      r_row_w      <= '0;
      r_din        <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_wr_en      <= w_wr_en_nx;
      r_col_w      <= w_col_w_nx;
      r_row_w      <= w_row_w_nx;
      r_din        <= w_din_nx;
      r_sweep_done <= w_sweep_done_nx;
    end
  end

  assign busy_o       = (r_state == CLEAR);
  assign wr_en_o      = r_wr_en;
  assign col_w_o      = r_col_w;
  assign row_w_o      = r_row_w;
  assign din_o        = r_din;
  assign cursor_col_o = w_cur_col;
  assign cursor_row_o = w_cur_row;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: linear-position screen model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_text_buffer_writer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       valid = 1'b0;
  logic [6:0] ch = '0;
  logic       clr = 1'b0;
  logic       ready, busy, wr_en;
  logic [6:0] col_w, din;
  logic [4:0] row_w;
  logic [6:0] cur_col;
  logic [4:0] cur_row;

  always #5 clk = ~clk;

  text_buffer_writer #(
    .COLS(80), .ROWS(30), .CHAR_W(7), .COL_W(7), .ROW_W(5), .CLEAR_CHAR(7'd0)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .char_valid_i(valid), .char_i(ch),
    .char_ready_o(ready), .clear_i(clr), .busy_o(busy), .wr_en_o(wr_en),
    .col_w_o(col_w), .row_w_o(row_w), .din_o(din),
    .cursor_col_o(cur_col), .cursor_row_o(cur_row)
  );

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Screen model: cursor as a linear row-major position, sweep as a tile count.
  bit m_busy = 1'b1;
  int m_k = 0;
  bit m_wr = 1'b0;
  int m_col = 0, m_row = 0, m_din = 0, m_pos = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 1'b1; m_k = 0; m_wr = 1'b0;
      m_col = 0; m_row = 0; m_din = 0; m_pos = 0;
    end else if (m_busy) begin
      if (m_k < 2400) begin
        m_wr = 1'b1; m_col = m_k % 80; m_row = m_k / 80; m_din = 0; m_k++;
      end else begin
        m_wr = 1'b0; m_busy = 1'b0; m_pos = 0;
      end
    end else begin
      m_wr = 1'b0;
      if (clr) begin
        m_busy = 1'b1; m_k = 0;
      end else if (valid) begin
        case (int'(ch))
          13: m_pos = (m_pos / 80) * 80;
          10: m_pos = ((m_pos / 80 + 1) % 30) * 80;
          8: begin
            if (m_pos > 0) m_pos--;
            m_wr = 1'b1; m_col = m_pos % 80; m_row = m_pos / 80; m_din = 0;
          end
          12: begin m_busy = 1'b1; m_k = 0; end
          default: begin
            m_wr = 1'b1; m_col = m_pos % 80; m_row = m_pos / 80; m_din = int'(ch);
            m_pos = (m_pos + 1) % 2400;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    cmp("wr_en", int'(wr_en), int'(m_wr));
    cmp("col_w", int'(col_w), m_col);
    cmp("row_w", int'(row_w), m_row);
    cmp("din", int'(din), m_din);
    cmp("busy", int'(busy), int'(m_busy));
    cmp("ready", int'(ready), int'(!m_busy && !clr));
    if (!m_busy) begin
      cmp("cursor_col", int'(cur_col), m_pos % 80);
      cmp("cursor_row", int'(cur_row), m_pos / 80);
    end
    if (wr_en && busy) pulses++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [6:0] c);
    valid = 1'b1;
    ch = c;
    step(1);
  endtask

  task automatic put_text(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] c;
      c = 8'h61 + 8'(i % 26);
      put(c[6:0]);
    end
  endtask

  task automatic chk_cursor(input string nm, input int c, input int r);
    cmp({nm, "_col"}, int'(cur_col), c);
    cmp({nm, "_row"}, int'(cur_row), r);
  endtask

  task automatic chk_write(input string nm, input int c, input int r, input int d);
    cmp({nm, "_wr"}, int'(wr_en), 1);
    cmp({nm, "_col"}, int'(col_w), c);
    cmp({nm, "_row"}, int'(row_w), r);
    cmp({nm, "_din"}, int'(din), d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    #1 rstn = 1'b0;
    step(3);
    cmp("rst_wr", int'(wr_en), 0);
    cmp("rst_busy", int'(busy), 1);
    cmp("rst_din", int'(din), 0);
    chk_cursor("rst_cur", 0, 0);
    rstn = 1'b1;
    p0 = pulses;

    step(2400);
    chk_write("sweep_last", 79, 29, 0);
    cmp("sweep_busy", int'(busy), 1);
    step(1);
    cmp("sweep_end_busy", int'(busy), 0);
    cmp("sweep_end_ready", int'(ready), 1);
    cmp("sweep_end_wr", int'(wr_en), 0);
    cmp("sweep_pulses", pulses - p0, 2400);
    chk_cursor("sweep_cur", 0, 0);

    put(7'h41);
    chk_write("char_a", 0, 0, 8'h41);
    put(7'h42);
    chk_write("char_b", 1, 0, 8'h42);
    valid = 1'b0;
    chk_cursor("ab_cur", 2, 0);
    step(1);
    cmp("idle_wr", int'(wr_en), 0);

    put(7'h0C);
    valid = 1'b0;
    cmp("ff_busy", int'(busy), 1);
    cmp("ff_wr", int'(wr_en), 0);
    step(2401);
    cmp("ff_done", int'(busy), 0);
    chk_cursor("ff_cur", 0, 0);

    put_text(80);
    put(7'h58);
    chk_write("row1", 0, 1, 8'h58);
    put_text(2319);
    valid = 1'b0;
    chk_cursor("wrap_cur", 0, 0);

    put_text(245);
    chk_cursor("pre_lf", 5, 3);
    put(7'h0A);
    cmp("lf_wr", int'(wr_en), 0);
    chk_cursor("lf_cur", 0, 4);
    put_text(7);
    put(7'h0D);
    cmp("cr_wr", int'(wr_en), 0);
    chk_cursor("cr_cur", 0, 4);
    put_text(2240);
    chk_cursor("pre_bs", 0, 2);
    put(7'h08);
    chk_write("bs_row", 79, 1, 0);
    chk_cursor("bs_row_cur", 79, 1);
    put_text(2241);
    chk_cursor("pre_bs0", 0, 0);
    put(7'h08);
    chk_write("bs_home", 0, 0, 0);
    chk_cursor("bs_home_cur", 0, 0);
    put(7'h51);
    put(7'h08);
    chk_write("bs_col", 0, 0, 0);
    valid = 1'b0;
    step(1);

    clr = 1'b1;
    valid = 1'b1;
    ch = 7'h41;
    #1;
    cmp("clr_ready", int'(ready), 0);
    p0 = pulses;
    step(1);
    cmp("clr_busy", int'(busy), 1);
    cmp("clr_wr", int'(wr_en), 0);
    step(5);
    clr = 1'b0;
    step(2395);
    chk_write("clr_last", 79, 29, 0);
    step(1);
    cmp("clr_end_busy", int'(busy), 0);
    cmp("clr_end_ready", int'(ready), 1);
    cmp("clr_pulses", pulses - p0, 2400);
    step(1);
    chk_write("clr_char", 0, 0, 8'h41);
    valid = 1'b0;
    step(1);

    rstn = 1'b0;
    #1;
    cmp("arst_wr", int'(wr_en), 0);
    cmp("arst_busy", int'(busy), 1);
    step(1);
    rstn = 1'b1;
    step(980);
    chk_write("mid_tile", 19, 12, 0);
    rstn = 1'b0;
    #1;
    cmp("mid_rst_wr", int'(wr_en), 0);
    cmp("mid_rst_col", int'(col_w), 0);
    step(1);
    rstn = 1'b1;
    p0 = pulses;
    step(1);
    chk_write("restart", 0, 0, 0);
    step(2399);
    chk_write("restart_last", 79, 29, 0);
    step(1);
    cmp("restart_done", int'(busy), 0);
    cmp("restart_pulses", pulses - p0, 2400);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
